// File: rtl/sipo_pkg.sv
// Shared constants, counter-width helper and counter type for the SIPO shift register.
// Pure declarations: no latency, no flow control.
package sipo_pkg;

   localparam int SIPO_DEFAULT_WIDTH = 4;
   localparam int SIPO_MIN_WIDTH     = 2;
   localparam int SIPO_MAX_WIDTH     = 32;

   // Wide enough for a bit index at the largest legal WIDTH.
   typedef logic [4:0] sipo_cnt_t;

   function automatic int sipo_cnt_w(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage : sipo_pkg

// File: rtl/sipo_bit_cnt.sv
// Modulo-WIDTH bit counter with a registered one-cycle strobe when a word completes.
// Latency: the strobe rises on the edge that shifts the WIDTH-th bit; no backpressure.
module sipo_bit_cnt
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   output logic word_vld_o
);

   localparam int CW = sipo_cnt_w(WIDTH);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          vld_q, vld_d;
   logic          last_bit;

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      vld_d = last_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   assign word_vld_o = vld_q;

endmodule : sipo_bit_cnt

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register, MSB first; bit on p_out[0] one edge after sampling.
// No backpressure: shifts every clock. SIPO_WORD_VALID_EN adds the word_valid strobe.
module sipo_shift_reg
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_in,
   output logic [WIDTH-1:0] p_out
`ifdef SIPO_WORD_VALID_EN
   ,
   output logic             word_valid
`endif
);

   if (WIDTH < SIPO_MIN_WIDTH || WIDTH > SIPO_MAX_WIDTH) begin : g_bad_width
      $error("sipo_shift_reg: WIDTH must be in 2..32");
   end

   logic [WIDTH-1:0] shift_q, shift_d;

   always_comb begin
      shift_d = {shift_q[WIDTH-2:0], s_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign p_out = shift_q;

`ifdef SIPO_WORD_VALID_EN
   sipo_bit_cnt #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .word_vld_o (word_valid)
   );
`endif

endmodule : sipo_shift_reg

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg at WIDTH=4 and WIDTH=8, driven in lockstep against a bit-history model.
// Optional word_valid checks follow SIPO_WORD_VALID_EN.
module tb_sipo_shift_reg;
   import sipo_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       s_in;
   logic [3:0] p4;
   logic [7:0] p8;
`ifdef SIPO_WORD_VALID_EN
   logic       wv4;
   logic       wv8;
`endif

   int n_asserts = 0;
   int n_fails   = 0;

   // Every bit sampled since the last reset, oldest first.
   logic hist[$];

   sipo_shift_reg #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .s_in  (s_in),
      .p_out (p4)
`ifdef SIPO_WORD_VALID_EN
      ,
      .word_valid (wv4)
`endif
   );

   sipo_shift_reg #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .s_in  (s_in),
      .p_out (p8)
`ifdef SIPO_WORD_VALID_EN
      ,
      .word_valid (wv8)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Most recent w bits, newest in bit 0; positions not yet filled are zero.
   function automatic logic [31:0] exp_word(input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++)
         if (i < hist.size()) r[i] = hist[hist.size() - 1 - i];
      return r;
   endfunction

   function automatic logic exp_valid(input int w);
      sipo_cnt_t phase;
      phase = sipo_cnt_t'(hist.size() % w);
      return (hist.size() > 0) && (phase == '0);
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, "_p4"}, 32'(p4), exp_word(4));
      check_eq({tag, "_p8"}, 32'(p8), exp_word(8));
`ifdef SIPO_WORD_VALID_EN
      check_eq({tag, "_wv4"}, 32'(wv4), 32'(exp_valid(4)));
      check_eq({tag, "_wv8"}, 32'(wv8), 32'(exp_valid(8)));
`endif
   endtask

   // Called between edges; returns 1 time unit after the edge that sampled b.
   task automatic step(input logic b, input string tag);
      s_in = b;
      @(posedge clk);
      #1;
      hist.push_back(b);
      check_all(tag);
   endtask

   // Asserts reset off-edge, checks the immediate clear, holds through an edge, releases on negedge.
   task automatic do_reset(input int offset);
      #(offset);
      rst_n = 1'b0;
      #1;
      hist.delete();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic shift_seq(input logic [7:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) step(bits[i], tag);
   endtask

   initial begin
      rst_n = 1'b1;
      s_in  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all("reset_state");
      check_eq("reset_p4_zero", 32'(p4), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      shift_seq(8'b1010, 4, "seq1010");
      check_eq("p4_1010", 32'(p4), 32'hA);

      do_reset(2);
      shift_seq(8'b11, 2, "pre_mid_rst");
      do_reset(3);
      check_eq("mid_rst_zero", 32'(p4), 32'h0);
      shift_seq(8'b0110, 4, "realign");

      do_reset(1);
      shift_seq(8'b1111_0000, 8, "fill_drain");
      check_eq("p4_drained", 32'(p4), 32'h0);
      check_eq("p8_f0", 32'(p8), 32'hF0);

      do_reset(2);
      shift_seq(8'b1100, 4, "seq1100");
      check_eq("p4_1100", 32'(p4), 32'hC);
      do_reset(2);
      shift_seq(8'b0101, 4, "seq0101");
      check_eq("p4_0101", 32'(p4), 32'h5);

      do_reset(1);
      shift_seq(8'b101101, 6, "cont6");
      check_eq("p4_1101", 32'(p4), 32'hD);
      shift_seq(8'b01, 2, "cont8");

      do_reset(3);
      shift_seq(8'hA5, 8, "a5");
      check_eq("p8_a5", 32'(p8), 32'hA5);

      for (int k = 0; k < 400; k++) begin
         if (($urandom % 37) == 0) do_reset(int'($urandom_range(1, 3)));
         else step(1'($urandom % 2), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule : tb_sipo_shift_reg
